// File: rtl/floo_pkg.sv
// Shared types and helpers for the FlooNoC virtual-channel link receiver.
//   floo_link_err_t : sticky link protocol error flags (multi, unrdy)
//   idx_width()     : bits needed to index n items (at least 1)
package floo_pkg;

  typedef struct packed {
    logic multi;  // more than one VC valid in a single cycle
    logic unrdy;  // valid asserted on a VC that was not ready
  } floo_link_err_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/floo_vc_link_rx_if.sv
// Bundle of the link-side and consumer-side signals of floo_vc_link_rx.
//   Link side     : valid_i (per VC), ready_o (per VC), data_i (shared flit)
//   Consumer side : valid_o, ready_i, data_o (per-VC head flit), usage_o
//   Error side    : err_multi_o, err_unrdy_o, drop_cnt_o, clr_err_i
// Modports: slave = the receiver, master = whoever drives the link and
// consumes the VC streams.
interface floo_vc_link_rx_if import floo_pkg::*; #(
  parameter int unsigned NumVirtChannels = 2,
  parameter type         flit_t          = logic,
  parameter int unsigned Depth           = 2,
  parameter int unsigned CntWidth        = 8
);
  localparam int unsigned UsageW = idx_width(Depth + 1);

  logic [NumVirtChannels-1:0]               valid_i;
  logic [NumVirtChannels-1:0]               ready_o;
  flit_t                                    data_i;
  logic [NumVirtChannels-1:0]               valid_o;
  logic [NumVirtChannels-1:0]               ready_i;
  flit_t                                    data_o [NumVirtChannels];
  logic [NumVirtChannels-1:0][UsageW-1:0]   usage_o;
  logic                                     err_multi_o;
  logic                                     err_unrdy_o;
  logic [NumVirtChannels-1:0][CntWidth-1:0] drop_cnt_o;
  logic                                     clr_err_i;

  modport slave (
    input  valid_i, data_i, ready_i, clr_err_i,
    output ready_o, valid_o, data_o, usage_o, err_multi_o, err_unrdy_o, drop_cnt_o
  );

  modport master (
    output valid_i, data_i, ready_i, clr_err_i,
    input  ready_o, valid_o, data_o, usage_o, err_multi_o, err_unrdy_o, drop_cnt_o
  );

endinterface

// File: rtl/floo_vc_rx_fifo.sv
// Single-VC receive FIFO without fall-through: a flit written at cycle t is
// visible at data_o from t+1. full_o/empty_o come from registered occupancy
// only, so the link-side ready never combinationally depends on a pop.
//   clk_i, rst_i : clock, asynchronous active-high reset (empties the FIFO)
//   push_i/data_i: write data_i at the tail (caller guarantees !full_o)
//   pop_i        : advance the head (caller guarantees !empty_o)
//   data_o       : head entry
//   usage_o      : number of stored entries
//   full_o/empty_o
module floo_vc_rx_fifo import floo_pkg::*; #(
  parameter type         flit_t = logic,
  parameter int unsigned Depth  = 2,
  parameter int unsigned UsageW = idx_width(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  flit_t             data_i,
  input  logic              pop_i,
  output flit_t             data_o,
  output logic [UsageW-1:0] usage_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int unsigned PtrW = idx_width(Depth);

  flit_t             mem_q [Depth];
  logic [UsageW-1:0] usage_q;
  logic [PtrW-1:0]   wr_idx;
  logic [PtrW-1:0]   rd_idx;

  if (Depth == 1) begin : g_single
    // A single entry is both head and tail.
    assign wr_idx = '0;
    assign rd_idx = '0;
  end else begin : g_ptr
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_i) begin
          wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop_i) begin
          rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
      end
    end

    assign wr_idx = wr_ptr_q;
    assign rd_idx = rd_ptr_q;
  end

  // Storage carries data only and is never reset.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_idx] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      usage_q <= '0;
    end else begin
      case ({push_i, pop_i})
        2'b10:   usage_q <= usage_q + UsageW'(1);
        2'b01:   usage_q <= usage_q - UsageW'(1);
        default: usage_q <= usage_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_idx];
  assign usage_o = usage_q;
  assign full_o  = (usage_q == UsageW'(Depth));
  assign empty_o = (usage_q == '0);

endmodule

// File: rtl/floo_vc_link_rx.sv
// Receiving end of a virtual-channel link. One shared flit bus carries
// per-VC valid/ready handshakes; each VC is buffered in its own FIFO and
// presented to the consumer as an independent valid/ready/data stream.
// Link protocol violations (several VCs valid at once, or valid on a VC that
// is not ready) drop the flit, set sticky flags and bump saturating per-VC
// drop counters.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus (slave)  : valid_i/ready_o/data_i link side, valid_o/ready_i/data_o/
//                  usage_o consumer side, err_multi_o/err_unrdy_o/drop_cnt_o
//                  error reporting, clr_err_i synchronous error clear
module floo_vc_link_rx import floo_pkg::*; #(
  parameter int unsigned NumVirtChannels = 2,
  parameter type         flit_t          = logic,
  parameter int unsigned Depth           = 2,
  parameter int unsigned CntWidth        = 8
) (
  input logic               clk_i,
  input logic               rst_i,
  floo_vc_link_rx_if.slave  bus
);
  localparam int unsigned UsageW = idx_width(Depth + 1);

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] cnt);
    return (&cnt) ? cnt : cnt + CntWidth'(1);
  endfunction

  logic [NumVirtChannels-1:0]               ready;
  logic [NumVirtChannels-1:0]               valid;
  logic [NumVirtChannels-1:0]               push;
  logic [NumVirtChannels-1:0]               pop;
  logic [NumVirtChannels-1:0]               drop;
  logic                                     multi;
  floo_link_err_t                           err_set;
  floo_link_err_t                           err_q;
  logic [NumVirtChannels-1:0][CntWidth-1:0] drop_cnt_q;

  // A multi-valid cycle poisons every VC: nothing is written anywhere.
  assign multi = ($countones(bus.valid_i) > 1);
  assign push  = bus.valid_i & ready & {NumVirtChannels{~multi}};
  // Each offending VC counts once, even if it is both multi and not ready.
  assign drop  = bus.valid_i & (~ready | {NumVirtChannels{multi}});
  assign pop   = valid & bus.ready_i;

  assign err_set.multi = multi;
  assign err_set.unrdy = |(bus.valid_i & ~ready);

  for (genvar v = 0; v < NumVirtChannels; v++) begin : g_vc
    logic full;
    logic empty;

    floo_vc_rx_fifo #(
      .flit_t (flit_t),
      .Depth  (Depth),
      .UsageW (UsageW)
    ) i_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push[v]),
      .data_i  (bus.data_i),
      .pop_i   (pop[v]),
      .data_o  (bus.data_o[v]),
      .usage_o (bus.usage_o[v]),
      .full_o  (full),
      .empty_o (empty)
    );

    assign ready[v] = ~full;
    assign valid[v] = ~empty;
  end

  // Error stage: flags and counters land at the edge after the offence.
  // Clear wins over any simultaneous set or count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q      <= '0;
      drop_cnt_q <= '0;
    end else if (bus.clr_err_i) begin
      err_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      err_q <= err_q | err_set;
      for (int v = 0; v < NumVirtChannels; v++) begin
        if (drop[v]) begin
          drop_cnt_q[v] <= sat_inc(drop_cnt_q[v]);
        end
      end
    end
  end

  assign bus.ready_o     = ready;
  assign bus.valid_o     = valid;
  assign bus.err_multi_o = err_q.multi;
  assign bus.err_unrdy_o = err_q.unrdy;
  assign bus.drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_floo_vc_link_rx.sv
// Directed bench for floo_vc_link_rx (2 VCs, Depth 2, 2-bit drop counters,
// 8-bit flits). Expected flits are queued per VC as stimulus is issued; a
// monitor pops and compares on every consumer handshake.
module tb_floo_vc_link_rx;
  typedef logic [7:0] flit_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  floo_vc_link_rx_if #(
    .NumVirtChannels (2),
    .flit_t          (flit_t),
    .Depth           (2),
    .CntWidth        (2)
  ) link ();

  floo_vc_link_rx #(
    .NumVirtChannels (2),
    .flit_t          (flit_t),
    .Depth           (2),
    .CntWidth        (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (link)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  flit_t exp_q0[$];
  flit_t exp_q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every consumer handshake must match the oldest
  // expected flit of that VC.
  always @(negedge clk) begin
    if (!rst) begin
      for (int v = 0; v < 2; v++) begin
        if (link.valid_o[v] && link.ready_i[v]) begin
          flit_t exp;
          logic  have;
          have = 1'b0;
          exp  = '0;
          if (v == 0 && exp_q0.size() > 0) begin exp = exp_q0.pop_front(); have = 1'b1; end
          if (v == 1 && exp_q1.size() > 0) begin exp = exp_q1.pop_front(); have = 1'b1; end
          if (have) begin
            check($sformatf("pop_vc%0d", v), 32'(link.data_o[v]), 32'(exp));
          end else begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_vc%0d: got unexpected flit 0x%0h, expected no flit", v, link.data_o[v]);
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] vld, input flit_t d);
    link.valid_i = vld;
    link.data_i  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    link.valid_i   = '0;
    link.data_i    = '0;
    link.ready_i   = '0;
    link.clr_err_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready", 32'(link.ready_o), 32'h3);
    check("rst_valid", 32'(link.valid_o), 32'h0);
    check("rst_usage", 32'(link.usage_o), 32'h0);
    check("rst_err", 32'({link.err_multi_o, link.err_unrdy_o}), 32'h0);
    check("rst_drop", 32'(link.drop_cnt_o), 32'h0);

    // Stream A1..A4 on VC0 with an always-ready consumer
    next_cycle();
    link.ready_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, flit_t'(8'hA1 + i));
      exp_q0.push_back(flit_t'(8'hA1 + i));
      @(negedge clk);
      check("stream_ready0", 32'(link.ready_o[0]), 32'h1);
      if (i > 0) check("stream_usage0", 32'(link.usage_o[0]), 32'h1);
      next_cycle();
    end
    drive(2'b00, '0);
    repeat (2) next_cycle();
    check("stream_drained", 32'(exp_q0.size()), 32'h0);

    // VC1 back-pressure: B1, B2 fill it, then drain
    link.ready_i = 2'b00;
    drive(2'b10, 8'hB1); exp_q1.push_back(8'hB1);
    @(negedge clk);
    check("bp_ready1_a", 32'(link.ready_o[1]), 32'h1);
    next_cycle();
    drive(2'b10, 8'hB2); exp_q1.push_back(8'hB2);
    @(negedge clk);
    check("bp_ready1_b", 32'(link.ready_o[1]), 32'h1);
    next_cycle();
    drive(2'b00, '0);
    @(negedge clk);
    check("bp_full_ready1", 32'(link.ready_o[1]), 32'h0);
    check("bp_full_usage1", 32'(link.usage_o[1]), 32'h2);
    next_cycle();
    link.ready_i = 2'b10;
    @(negedge clk);
    check("bp_pop_no_bypass", 32'(link.ready_o[1]), 32'h0);
    next_cycle();
    @(negedge clk);
    check("bp_ready1_back", 32'(link.ready_o[1]), 32'h1);
    next_cycle();
    next_cycle();
    check("bp_drained", 32'(exp_q1.size()), 32'h0);

    // Multi-valid cycle
    link.ready_i = 2'b11;
    drive(2'b11, 8'hEE);
    next_cycle();
    drive(2'b00, '0);
    @(negedge clk);
    check("multi_flag", 32'(link.err_multi_o), 32'h1);
    check("multi_unrdy", 32'(link.err_unrdy_o), 32'h0);
    check("multi_drop", 32'(link.drop_cnt_o), 32'h5);
    check("multi_no_accept", 32'(link.usage_o), 32'h0);
    next_cycle();
    link.clr_err_i = 1'b1;
    next_cycle();
    link.clr_err_i = 1'b0;
    @(negedge clk);
    check("clr_err", 32'({link.err_multi_o, link.err_unrdy_o}), 32'h0);
    check("clr_drop", 32'(link.drop_cnt_o), 32'h0);
    next_cycle();

    // Fill VC0, then drive it while not ready
    link.ready_i = 2'b00;
    drive(2'b01, 8'hC1); exp_q0.push_back(8'hC1);
    next_cycle();
    drive(2'b01, 8'hC2); exp_q0.push_back(8'hC2);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, flit_t'(8'hD0 + i));
      next_cycle();
    end
    drive(2'b00, '0);
    @(negedge clk);
    check("unrdy_flag", 32'(link.err_unrdy_o), 32'h1);
    check("unrdy_multi", 32'(link.err_multi_o), 32'h0);
    check("unrdy_drop0", 32'(link.drop_cnt_o[0]), 32'h3);
    check("unrdy_drop1", 32'(link.drop_cnt_o[1]), 32'h0);
    check("unrdy_usage0", 32'(link.usage_o[0]), 32'h2);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      drive(2'b01, 8'hDD);
      next_cycle();
    end
    drive(2'b00, '0);
    @(negedge clk);
    check("sat_drop0", 32'(link.drop_cnt_o[0]), 32'h3);
    next_cycle();
    // Clear has priority over a simultaneous drop
    drive(2'b01, 8'hDE);
    link.clr_err_i = 1'b1;
    next_cycle();
    drive(2'b00, '0);
    link.clr_err_i = 1'b0;
    @(negedge clk);
    check("clr_prio_drop", 32'(link.drop_cnt_o), 32'h0);
    check("clr_prio_unrdy", 32'(link.err_unrdy_o), 32'h0);
    next_cycle();
    link.ready_i = 2'b01;
    repeat (3) next_cycle();
    check("unrdy_contents", 32'(exp_q0.size()), 32'h0);

    // Asynchronous reset with both FIFOs holding two flits
    link.ready_i = 2'b00;
    drive(2'b01, 8'hE1); next_cycle();
    drive(2'b10, 8'hF1); next_cycle();
    drive(2'b01, 8'hE2); next_cycle();
    drive(2'b10, 8'hF2); next_cycle();
    drive(2'b00, '0);
    @(negedge clk);
    check("pre_rst_usage", 32'(link.usage_o), 32'hA);
    next_cycle();
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(link.valid_o), 32'h0);
    check("async_rst_usage", 32'(link.usage_o), 32'h0);
    check("async_rst_ready", 32'(link.ready_o), 32'h3);
    next_cycle();
    rst = 1'b0;
    link.ready_i = 2'b11;
    drive(2'b10, 8'h5A); exp_q1.push_back(8'h5A);
    next_cycle();
    drive(2'b00, '0);
    repeat (2) next_cycle();
    check("post_rst_delivered", 32'(exp_q1.size()), 32'h0);
    check("end_q0_empty", 32'(exp_q0.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
